dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the byte-addressed data memory.
- Shares the single memory port between the core load/store path (core_*) and a debug/loader port (dbg_*).
- Each granted request is latched, the memory control strobes are driven for exactly one cycle, and a done pulse is returned with read data captured.
- Sits between the core datapath/debug interface and the data memory; the memory keeps synchronous write and asynchronous read.

Parameters:
- ADDR_W, 32, address width of both requester ports and mem_addr.
- MEM_BYTES, 41, number of bytes in the data memory; used only by the range check under DMEM_ARB_CHK_EN.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- core_req  input  1  core access request; held high until core_gnt.
- core_we  input  1  1 = store, 0 = load.
- core_mode  input  2  00 byte, 01 halfword, 10 word, 11 invalid.
- core_addr  input  ADDR_W  byte address.
- core_wdata  input  32  store data, low bytes used per mode.
- core_gnt  output  1  one-cycle pulse; request latched.
- core_done  output  1  one-cycle pulse; access complete, core_rdata valid.
- core_rdata  output  32  captured load data; holds until the next core load completes.
- dbg_req, dbg_we, dbg_mode, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata  same directions, widths and meanings as the core_* ports.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_mode  output  2  memory access size.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  asynchronous read data from memory (already sign-extended per mode).
- err  output  1  access error pulse, coincident with done; tied 0 without DMEM_ARB_CHK_EN.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=DBG.
  - All gnt/done/err, mem_read, mem_write = 0.
  - mem_mode/mem_addr/mem_wdata = 0; core_rdata = dbg_rdata = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no req, stay.
  - If exactly one req, select that port.
  - If both req, select the port != last_grant (round-robin); the core wins the first tie after reset.
  - On the edge: latch we/mode/addr/wdata of the winner, set owner, last_grant=owner, pulse owner's gnt, go to ACCESS.
- ACCESS, one cycle:
  - Drive mem_mode/mem_addr/mem_wdata from the latched values.
  - Latched we=1: mem_write=1, mem_read=0. Latched we=0: mem_read=1, mem_write=0.
  - mode=11: both strobes 0 (no-op).
  - On the edge: for a load, capture mem_rdata into owner's rdata (mode 11 captures 0). Go to RESP.
- RESP, one cycle: pulse owner's done; go to IDLE. mem_read/mem_write = 0.
- Latency: req sampled at edge E → gnt high cycle E+1, memory access in cycle E+1, done high cycle E+2, next grant earliest at E+3. One access per 3 cycles.
- Requests arriving in ACCESS/RESP wait; a req held continuously is re-granted in IDLE.
- Fields must be stable only on the IDLE sampling edge. Dropping req before gnt withdraws the request.
- The non-owner's rdata is never modified. A store never changes either rdata.
- gnt and done for the same port are never high in the same cycle.
- Reset mid-operation:
  - Asserting rst during ACCESS drops mem_write asynchronously, so the store must not commit.
  - The pending request is discarded; no done is issued.

Optional Feature:
- Macro DMEM_ARB_CHK_EN.
- Defined: in ACCESS the latched request is checked.
  - Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Range: addr + size > MEM_BYTES, where size = 1/2/4.
  - Invalid mode 11.
  - On any failure: both strobes 0, rdata unchanged, err=1 in the RESP cycle alongside done.
- Undefined: no checks; all modes 00–10 forwarded unmodified; mode 11 is a no-op with rdata=0; err tied 0.

Test Plan:
- Core word store addr=8, wdata=0xDEADBEEF, then core word load addr=8 → mem_write high exactly 1 cycle; core_gnt at E+1, core_done at E+2; core_rdata=0xDEADBEEF.
- core_req and dbg_req both high continuously after reset, each a byte load → grant order core, dbg, core, dbg; gnt pulses spaced 3 cycles apart; dbg_rdata never changes on core completions.
- dbg byte load addr=4 where byte=0x80 → dbg_rdata=0xFFFFFF80 (pass-through of memory sign extension); core_rdata unchanged.
- Core word store addr=12, rst pulsed during ACCESS → mem_write falls immediately; word at 12 unchanged; no core_done; all outputs 0; next request granted normally.
- Mode 11 load by core → no strobes; core_done pulses; core_rdata=0. With DMEM_ARB_CHK_EN, err=1 and core_rdata holds its previous value instead.
- With DMEM_ARB_CHK_EN: word load addr=6 (misaligned) and word load addr=40 (out of range) → err=1 with done, no strobes; halfword load addr=38 passes with err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between core and debug requesters.
// Round-robin grant, one access per three cycles (IDLE -> ACCESS -> RESP).
// Ports: clk, rst (async, active-high); core_*/dbg_* requester ports
//   (req, we, mode, addr, wdata in; gnt, done, rdata out); mem_* memory
//   port (read, write, mode, addr, wdata out; rdata in); err pulse out.
// Optional macro DMEM_ARB_CHK_EN: alignment/range/mode checks in ACCESS.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 41
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [1:0]        core_mode,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_gnt,
  output logic              core_done,
  output logic [31:0]       core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_mode,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [31:0]       dbg_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err
);

`ifdef DMEM_ARB_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;

  logic       last_dbg;
  logic       own_dbg;
  logic       lat_we;
  logic [1:0] lat_mode;
  logic       lat_bad;

  logic              any_req;
  logic              pick_dbg;
  logic              sel_we;
  logic [1:0]        sel_mode;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [ADDR_W:0]   sel_size;
  logic [ADDR_W:0]   sel_end;
  logic              misalign;
  logic              over;
  logic              sel_bad;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    any_req  = core_req | dbg_req;
    pick_dbg = dbg_req & (~core_req | ~last_dbg);
    if (pick_dbg) begin
      sel_we    = dbg_we;
      sel_mode  = dbg_mode;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end else begin
      sel_we    = core_we;
      sel_mode  = core_mode;
      sel_addr  = core_addr;
      sel_wdata = core_wdata;
    end
  end

  // Checks are evaluated on the grant edge and carried with the request.
  always_comb begin
    unique case (sel_mode)
      2'b00:   sel_size = (ADDR_W+1)'(1);
      2'b01:   sel_size = (ADDR_W+1)'(2);
      default: sel_size = (ADDR_W+1)'(4);
    endcase
    sel_end  = {1'b0, sel_addr} + sel_size;
    over     = sel_end > (ADDR_W+1)'(MEM_BYTES);
    misalign = ((sel_mode == 2'b01) & sel_addr[0])
             | ((sel_mode == 2'b10) & (|sel_addr[1:0]));
    sel_bad  = (sel_mode == 2'b11)
             | (CHK_EN & (misalign | over));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_dbg   <= 1'b1;
      own_dbg    <= 1'b0;
      lat_we     <= 1'b0;
      lat_mode   <= 2'b00;
      lat_bad    <= 1'b0;
      core_gnt   <= 1'b0;
      dbg_gnt    <= 1'b0;
      core_done  <= 1'b0;
      dbg_done   <= 1'b0;
      err        <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_mode   <= 2'b00;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            own_dbg   <= pick_dbg;
            last_dbg  <= pick_dbg;
            lat_we    <= sel_we;
            lat_mode  <= sel_mode;
            lat_bad   <= sel_bad;
            mem_mode  <= sel_mode;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_write <= sel_we & ~sel_bad;
            mem_read  <= ~sel_we & ~sel_bad;
            core_gnt  <= ~pick_dbg;
            dbg_gnt   <= pick_dbg;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          core_gnt  <= 1'b0;
          dbg_gnt   <= 1'b0;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          // Without checks an invalid-mode load returns zero;
          // with checks a rejected load leaves rdata alone.
          if (!lat_we) begin
            if (!lat_bad) begin
              if (own_dbg) dbg_rdata <= mem_rdata;
              else core_rdata <= mem_rdata;
            end else if (!CHK_EN && lat_mode == 2'b11) begin
              if (own_dbg) dbg_rdata <= '0;
              else core_rdata <= '0;
            end
          end
          core_done <= ~own_dbg;
          dbg_done  <= own_dbg;
          err       <= CHK_EN & lat_bad;
          state     <= RESP;
        end
        RESP: begin
          core_done <= 1'b0;
          dbg_done  <= 1'b0;
          err       <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a transaction-level model of the
// arbiter and a byte-array memory; outputs compared on every negedge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 0, core_we = 0;
  logic [1:0]  core_mode = 0;
  logic [31:0] core_addr = 0, core_wdata = 0;
  logic        core_gnt, core_done;
  logic [31:0] core_rdata;
  logic        dbg_req = 0, dbg_we = 0;
  logic [1:0]  dbg_mode = 0;
  logic [31:0] dbg_addr = 0, dbg_wdata = 0;
  logic        dbg_gnt, dbg_done;
  logic [31:0] dbg_rdata;
  logic        mem_read, mem_write;
  logic [1:0]  mem_mode;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        err;

  int errors = 0;
  int checks = 0;
  bit run = 0;

  dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(41)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we),
    .core_mode(core_mode), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_done(core_done), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_mode(dbg_mode), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory: synchronous write, asynchronous sign-extended read.
  logic [7:0] bmem [0:63];

  always @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < (1 << mem_mode) && i < 4; i++)
        if (mem_addr + i < 64)
          bmem[mem_addr + i] <= mem_wdata[8*i +: 8];
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr < 60) begin
      case (mem_mode)
        2'b00: mem_rdata = {{24{bmem[mem_addr][7]}},
                            bmem[mem_addr]};
        2'b01: mem_rdata = {{16{bmem[mem_addr+1][7]}},
                            bmem[mem_addr+1], bmem[mem_addr]};
        2'b10: mem_rdata = {bmem[mem_addr+3], bmem[mem_addr+2],
                            bmem[mem_addr+1], bmem[mem_addr]};
        default: mem_rdata = 32'h0;
      endcase
    end
  end

  // ---- transaction-level model ----
  logic [7:0]  smem [0:63];
  int          m_c = 0;
  int          tx_g = -100;
  bit          tx_own, tx_we, tx_bad, last = 1;
  logic [1:0]  tx_mode;
  logic [31:0] tx_addr, tx_wdata;
  logic [31:0] m_core = 0, m_dbg = 0;

  function automatic bit bad_req(input logic [1:0] md,
                                 input logic [31:0] a);
    int sz;
    if (md == 2'b11) return 1'b1;
    sz = 1 << md;
`ifdef DMEM_ARB_CHK_EN
    if (a % sz != 0) return 1'b1;
    if (longint'(a) + sz > 41) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ld(input logic [1:0] md,
                                     input logic [31:0] a);
    int v = 0;
    int sz = 1 << md;
    for (int i = 0; i < sz; i++) v |= int'(smem[a + i]) << (8 * i);
    if (sz == 1 && v >= 128) v -= 256;
    if (sz == 2 && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_g   <= -100;
      last   <= 1'b1;
      m_core <= 0;
      m_dbg  <= 0;
    end else begin
      int nc;
      bit pd;
      nc = m_c + 1;
      m_c <= nc;
      if (nc == tx_g + 1) begin
        if (tx_we && !tx_bad) begin
          for (int i = 0; i < (1 << tx_mode); i++)
            smem[tx_addr + i] <= tx_wdata[8*i +: 8];
        end
        if (!tx_we) begin
          logic [31:0] v;
          bit upd;
          upd = 1'b1;
          v = 32'h0;
          if (!tx_bad) v = ld(tx_mode, tx_addr);
`ifdef DMEM_ARB_CHK_EN
          else upd = 1'b0;
`endif
          if (upd && tx_own) m_dbg <= v;
          if (upd && !tx_own) m_core <= v;
        end
      end
      if (nc >= tx_g + 3 && (core_req || dbg_req)) begin
        pd = dbg_req && (!core_req || !last);
        tx_g   <= nc;
        tx_own <= pd;
        last   <= pd;
        tx_we    <= pd ? dbg_we : core_we;
        tx_mode  <= pd ? dbg_mode : core_mode;
        tx_addr  <= pd ? dbg_addr : core_addr;
        tx_wdata <= pd ? dbg_wdata : core_wdata;
        tx_bad   <= pd ? bad_req(dbg_mode, dbg_addr)
                       : bad_req(core_mode, core_addr);
      end
    end
  end

  // ---- compare + monitor ----
  bit gq[$];
  int gc[$];
  int cyc = 0;
  int wr_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (mem_write) wr_cnt++;
    if (core_gnt) begin gq.push_back(1'b0); gc.push_back(cyc); end
    if (dbg_gnt) begin gq.push_back(1'b1); gc.push_back(cyc); end
    if (run) begin
      bit acc, rsp;
      acc = (m_c == tx_g);
      rsp = (m_c == tx_g + 1);
      chk("core_gnt", 32'(core_gnt), 32'(acc && !tx_own));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(acc && tx_own));
      chk("core_done", 32'(core_done), 32'(rsp && !tx_own));
      chk("dbg_done", 32'(dbg_done), 32'(rsp && tx_own));
`ifdef DMEM_ARB_CHK_EN
      chk("err", 32'(err), 32'(rsp && tx_bad));
`else
      chk("err", 32'(err), 32'h0);
`endif
      chk("mem_write", 32'(mem_write),
          32'(acc && tx_we && !tx_bad));
      chk("mem_read", 32'(mem_read),
          32'(acc && !tx_we && !tx_bad));
      chk("core_rdata", core_rdata, m_core);
      chk("dbg_rdata", dbg_rdata, m_dbg);
      if (acc) begin
        chk("mem_mode", 32'(mem_mode), 32'(tx_mode));
        chk("mem_addr", mem_addr, tx_addr);
        chk("mem_wdata", mem_wdata, tx_wdata);
      end
    end
  end

  // ---- stimulus ----
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic xfer(input bit d, input bit we,
                      input logic [1:0] md,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      output bit e);
    int n;
    @(posedge clk);
    #2;
    if (d) begin
      dbg_req = 1; dbg_we = we; dbg_mode = md;
      dbg_addr = a; dbg_wdata = wd;
    end else begin
      core_req = 1; core_we = we; core_mode = md;
      core_addr = a; core_wdata = wd;
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(d ? dbg_gnt : core_gnt) && n < 8);
    core_req = 0;
    dbg_req = 0;
    chk("gnt_latency", 32'(n), 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(d ? dbg_done : core_done) && n < 8);
    chk("done_latency", 32'(n), 32'd1);
    e = err;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit e;
    int n;
    for (int i = 0; i < 64; i++) begin
      bmem[i] = 8'h10 + 8'(i);
      smem[i] = 8'h10 + 8'(i);
    end
    bmem[4] = 8'h80;
    smem[4] = 8'h80;

    do_reset();
    run = 1;
    #1;
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // word store then load
    wr_cnt = 0;
    xfer(0, 1, 2'b10, 32'd8, 32'hDEADBEEF, e);
    chk("store_wr_cycles", 32'(wr_cnt), 32'd1);
    xfer(0, 0, 2'b10, 32'd8, 32'h0, e);
    chk("load_word8", core_rdata, 32'hDEADBEEF);

    // contention right after reset
    do_reset();
    @(posedge clk);
    #2;
    gq.delete();
    gc.delete();
    core_req = 1; core_we = 0; core_mode = 2'b00; core_addr = 1;
    dbg_req = 1; dbg_we = 0; dbg_mode = 2'b00; dbg_addr = 2;
    n = 0;
    while (gq.size() < 4 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    core_req = 0;
    dbg_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rr_count", 32'(gq.size()), 32'd4);
    if (gq.size() >= 4) begin
      chk("rr_order0", 32'(gq[0]), 32'd0);
      chk("rr_order1", 32'(gq[1]), 32'd1);
      chk("rr_order2", 32'(gq[2]), 32'd0);
      chk("rr_order3", 32'(gq[3]), 32'd1);
      for (int i = 1; i < 4; i++)
        chk("rr_spacing", 32'(gc[i] - gc[i-1]), 32'd3);
    end
    chk("rr_core_rdata", core_rdata, 32'h00000011);
    chk("rr_dbg_rdata", dbg_rdata, 32'h00000012);

    // dbg byte load with sign bit set
    xfer(1, 0, 2'b00, 32'd4, 32'h0, e);
    chk("dbg_sext", dbg_rdata, 32'hFFFFFF80);
    chk("core_untouched", core_rdata, 32'h00000011);

    // reset during a store's access cycle
    @(posedge clk);
    #2;
    core_req = 1; core_we = 1; core_mode = 2'b10;
    core_addr = 12; core_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    chk("midrst_gnt", 32'(core_gnt), 32'd1);
    chk("midrst_wr_before", 32'(mem_write), 32'd1);
    core_req = 0;
    #1 rst = 1;
    #1;
    chk("midrst_wr_drop", 32'(mem_write), 32'd0);
    chk("midrst_gnt_drop", 32'(core_gnt), 32'd0);
    @(posedge clk);
    #2 rst = 0;
    repeat (3) @(posedge clk);
    chk("midrst_mem12",
        {bmem[15], bmem[14], bmem[13], bmem[12]}, 32'h1F1E1D1C);
    xfer(0, 0, 2'b10, 32'd12, 32'h0, e);
    chk("after_rst_load", core_rdata, 32'h1F1E1D1C);

    // invalid mode load
    xfer(0, 0, 2'b11, 32'd0, 32'h0, e);
`ifdef DMEM_ARB_CHK_EN
    chk("mode11_err", 32'(e), 32'd1);
    chk("mode11_rdata", core_rdata, 32'h1F1E1D1C);
    xfer(0, 0, 2'b10, 32'd6, 32'h0, e);
    chk("misalign_err", 32'(e), 32'd1);
    xfer(0, 0, 2'b10, 32'd40, 32'h0, e);
    chk("range_err", 32'(e), 32'd1);
    chk("range_rdata", core_rdata, 32'h1F1E1D1C);
`else
    chk("mode11_err", 32'(e), 32'd0);
    chk("mode11_rdata", core_rdata, 32'h0);
`endif
    xfer(0, 0, 2'b01, 32'd38, 32'h0, e);
    chk("half38_err", 32'(e), 32'd0);
    chk("half38_rdata", core_rdata, 32'h00003736);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
